// File: rtl/sram_slot_sched_if.sv
// Bus-side signals of the shared-SRAM slot scheduler.
// The master side drives requests and SRAM read data; the slave side is the scheduler.
interface sram_slot_sched_if;
   logic        snoop;
   logic        aux_req;
   logic        aux_we;
   logic [18:0] aux_addr;
   logic [7:0]  aux_wdata;
   logic [7:0]  sram_rd;
   logic        aux_ack;
   logic [7:0]  aux_rdata;
   logic        aux_sel;
   logic        aux_oe;
   logic        aux_nwe;
   logic        nAE;
   logic        nBE;
   logic [1:0]  phase;
   logic        lock;
   logic        aux_starved;
   logic        sync_err;

   modport master (
      output snoop, aux_req, aux_we, aux_addr, aux_wdata, sram_rd,
      input  aux_ack, aux_rdata, aux_sel, aux_oe, aux_nwe, nAE, nBE,
             phase, lock, aux_starved, sync_err
   );

   modport slave (
      input  snoop, aux_req, aux_we, aux_addr, aux_wdata, sram_rd,
      output aux_ack, aux_rdata, aux_sel, aux_oe, aux_nwe, nAE, nBE,
             phase, lock, aux_starved, sync_err
   );
endinterface

// File: rtl/sram_slot_sched.sv
// Time-division scheduler for the shared SRAM: 4-phase slot counter locked to the
// Gigatron CLK, /AE and /BE strobes, and aux requester access in the free half-cycle.
module sram_slot_sched #(
   parameter int unsigned LOCK_COUNT   = 4,
   parameter int unsigned STARVE_W     = 8,
   parameter int unsigned STARVE_LIMIT = 200
) (
   input logic              CLKx4,
   input logic              nRESET,
   input logic              CLK,
   sram_slot_sched_if.slave bus
);

   localparam int unsigned LCW = $clog2(LOCK_COUNT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STRB, S_DONE} state_e;

   logic                clk_meta_q, clk_sync_q, clk_prev_q;
   logic                clk_rise, wrap, grant;
   logic [1:0]          phase_q, phase_d;
   logic                nae_q, nae_d, nbe_q, nbe_d;
   logic [LCW-1:0]      lock_cnt_q, lock_cnt_d;
   logic                lock_q, lock_d;
   logic                sync_err_q, sync_err_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                starved_q, starved_d;
   state_e              state_q, state_d;
   logic                sel_q, sel_d, oe_q, oe_d, nwe_q, nwe_d, ack_q, ack_d;
   logic                we_q, we_d;
   logic [7:0]          rdata_q, rdata_d;

   assign clk_rise = clk_sync_q & ~clk_prev_q;
   assign wrap     = (phase_q == 2'd3);
   assign grant    = wrap & lock_q & bus.aux_req & ~bus.snoop & (state_q == S_IDLE);

   // Phase counter and CLK lock. A phase-3 slot without a CLK edge (stopped or
   // stretched CLK) breaks the run of aligned edges, so lock falls as well.
   always_comb begin
      phase_d    = phase_q + 2'd1;
      lock_cnt_d = lock_cnt_q;
      sync_err_d = sync_err_q;
      if (clk_rise && !wrap) begin
         phase_d    = '0;
         lock_cnt_d = '0;
         if (lock_q) sync_err_d = 1'b1;
      end else if (wrap) begin
         if (!clk_rise)                          lock_cnt_d = '0;
         else if (lock_cnt_q != LCW'(LOCK_COUNT)) lock_cnt_d = lock_cnt_q + LCW'(1);
      end
      lock_d = (lock_cnt_d == LCW'(LOCK_COUNT));
      nae_d  = ~phase_d[1];
      nbe_d  = ~(phase_d[1] ^ phase_d[0]);
   end

   always_comb begin
      starve_d = starve_q;
      if (!bus.aux_req || grant)      starve_d = '0;
      else if (wrap && starve_q != '1) starve_d = starve_q + STARVE_W'(1);
      starved_d = starved_q | (starve_d > STARVE_W'(STARVE_LIMIT));
   end

   // Strobe outputs are registered one edge ahead of the slot they belong to,
   // so ack and the sel/oe release land together on entry to DONE (phase 2).
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      oe_d    = oe_q;
      nwe_d   = nwe_q;
      ack_d   = 1'b0;
      we_d    = we_q;
      rdata_d = rdata_q;
      if (state_q != S_IDLE && !lock_q) begin
         state_d = S_IDLE;
         sel_d   = 1'b0;
         oe_d    = 1'b0;
         nwe_d   = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: if (grant) begin
               state_d = S_ADDR;
               sel_d   = 1'b1;
               oe_d    = bus.aux_we;
               we_d    = bus.aux_we;
            end
            S_ADDR: begin
               state_d = S_STRB;
               if (we_q) nwe_d = 1'b0;
            end
            S_STRB: begin
               state_d = S_DONE;
               nwe_d   = 1'b1;
               ack_d   = 1'b1;
               sel_d   = 1'b0;
               oe_d    = 1'b0;
               if (!we_q) rdata_d = bus.sram_rd;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLKx4 or negedge nRESET) begin
      if (!nRESET) begin
         clk_meta_q <= 1'b0;
         clk_sync_q <= 1'b0;
         clk_prev_q <= 1'b0;
         phase_q    <= '0;
         nae_q      <= 1'b1;
         nbe_q      <= 1'b1;
         lock_cnt_q <= '0;
         lock_q     <= 1'b0;
         sync_err_q <= 1'b0;
         starve_q   <= '0;
         starved_q  <= 1'b0;
         state_q    <= S_IDLE;
         sel_q      <= 1'b0;
         oe_q       <= 1'b0;
         nwe_q      <= 1'b1;
         ack_q      <= 1'b0;
         we_q       <= 1'b0;
         rdata_q    <= '0;
      end else begin
         clk_meta_q <= CLK;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         phase_q    <= phase_d;
         nae_q      <= nae_d;
         nbe_q      <= nbe_d;
         lock_cnt_q <= lock_cnt_d;
         lock_q     <= lock_d;
         sync_err_q <= sync_err_d;
         starve_q   <= starve_d;
         starved_q  <= starved_d;
         state_q    <= state_d;
         sel_q      <= sel_d;
         oe_q       <= oe_d;
         nwe_q      <= nwe_d;
         ack_q      <= ack_d;
         we_q       <= we_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.phase       = phase_q;
   assign bus.nAE         = nae_q;
   assign bus.nBE         = nbe_q;
   assign bus.lock        = lock_q;
   assign bus.sync_err    = sync_err_q;
   assign bus.aux_starved = starved_q;
   assign bus.aux_sel     = sel_q;
   assign bus.aux_oe      = oe_q;
   assign bus.aux_nwe     = nwe_q;
   assign bus.aux_ack     = ack_q;
   assign bus.aux_rdata   = rdata_q;

endmodule

// File: tb/tb_sram_slot_sched.sv
// Directed bench for sram_slot_sched: slot strobes, CLK lock, aux transfers,
// starvation, lock loss mid-transfer and asynchronous reset.
module tb_sram_slot_sched;

   logic        clk4 = 1'b0;
   logic        nrst;
   logic        gclk;
   logic        gen_en, clk_man;
   int unsigned gc = 0;
   int          checks = 0;
   int          errors = 0;

   sram_slot_sched_if bus ();

   sram_slot_sched #(.LOCK_COUNT(4), .STARVE_W(8), .STARVE_LIMIT(200)) dut (
      .CLKx4  (clk4),
      .nRESET (nrst),
      .CLK    (gclk),
      .bus    (bus)
   );

   always #5 clk4 = ~clk4;

   // Gigatron CLK = CLKx4 / 4, optionally overridden by hand for glitches and stalls
   always @(negedge clk4) gc <= gc + 1;
   assign gclk = gen_en ? gc[1] : clk_man;

   typedef struct {
      logic [1:0] ph;
      logic       nae;
      logic       nbe;
   } ph_t;

   typedef struct {
      logic        snp;
      logic        we;
      logic [18:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rd;
      logic [3:0]  sel;
      logic [3:0]  oe;
      logic [3:0]  nwe;
      logic [3:0]  ack;
      logic [7:0]  rdata;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_phase(input logic [1:0] p, input string name);
      int unsigned n = 0;
      do begin
         @(negedge clk4);
         n++;
      end while (bus.phase !== p && n < 16);
      if (bus.phase !== p) check(name, 32'(bus.phase), 32'(p));
   endtask

   task automatic wait_lock(input int unsigned bound, input string name);
      int unsigned n = 0;
      while (bus.lock !== 1'b1 && n < bound) begin
         @(negedge clk4);
         n++;
      end
      check(name, 32'(bus.lock), 1);
   endtask

   always @(negedge clk4) begin
      if (nrst === 1'b1) begin
         checks++;
         if (bus.nAE === 1'b0 && (bus.aux_sel !== 1'b0 || bus.aux_oe !== 1'b0)) begin
            errors++;
            $display("FAIL sel_oe_in_gig_slot: sel=%b oe=%b with nAE=0, required 0", bus.aux_sel, bus.aux_oe);
         end
      end
   end

   initial begin
      #300000;
      errors++;
      $display("FAIL global_timeout: bench did not complete, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      ph_t         pt[4];
      vec_t        vt[6];
      int unsigned wraps, n, acks;
      logic        sel_seen;

      pt[0] = '{2'd0, 1'b1, 1'b1};
      pt[1] = '{2'd1, 1'b1, 1'b0};
      pt[2] = '{2'd2, 1'b0, 1'b0};
      pt[3] = '{2'd3, 1'b0, 1'b1};
      vt[0] = '{1'b0, 1'b1, 19'h12345, 8'hA5, 8'h55, 4'b0011, 4'b0011, 4'b1101, 4'b0100, 8'h00};
      vt[1] = '{1'b0, 1'b0, 19'h00100, 8'h00, 8'h3C, 4'b0011, 4'b0000, 4'b1111, 4'b0100, 8'h3C};
      vt[2] = '{1'b0, 1'b1, 19'h7FFFF, 8'hFF, 8'h99, 4'b0011, 4'b0011, 4'b1101, 4'b0100, 8'h3C};
      vt[3] = '{1'b0, 1'b0, 19'h7FFFF, 8'h00, 8'hFF, 4'b0011, 4'b0000, 4'b1111, 4'b0100, 8'hFF};
      vt[4] = '{1'b1, 1'b0, 19'h00200, 8'h00, 8'h11, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 8'hFF};
      vt[5] = '{1'b0, 1'b0, 19'h00000, 8'h00, 8'h00, 4'b0011, 4'b0000, 4'b1111, 4'b0100, 8'h00};

      gen_en        = 1'b1;
      clk_man       = 1'b0;
      bus.snoop     = 1'b0;
      bus.aux_req   = 1'b0;
      bus.aux_we    = 1'b0;
      bus.aux_addr  = '0;
      bus.aux_wdata = '0;
      bus.sram_rd   = '0;
      nrst          = 1'b1;
      #1 nrst = 1'b0;

      // reset values
      #30;
      check("rst_phase",    32'(bus.phase), 0);
      check("rst_nAE",      32'(bus.nAE), 1);
      check("rst_nBE",      32'(bus.nBE), 1);
      check("rst_lock",     32'(bus.lock), 0);
      check("rst_ack",      32'(bus.aux_ack), 0);
      check("rst_rdata",    32'(bus.aux_rdata), 0);
      check("rst_sel",      32'(bus.aux_sel), 0);
      check("rst_oe",       32'(bus.aux_oe), 0);
      check("rst_nwe",      32'(bus.aux_nwe), 1);
      check("rst_starved",  32'(bus.aux_starved), 0);
      check("rst_sync_err", 32'(bus.sync_err), 0);

      @(posedge clk4);
      #2 nrst = 1'b1;

      // at least four aligned edges are needed, so no lock within 12 cycles
      repeat (12) @(negedge clk4);
      check("lock_not_early", 32'(bus.lock), 0);
      wait_lock(80, "lock_acquire");
      check("lock_no_sync_err", 32'(bus.sync_err), 0);

      wait_phase(2'd0, "pattern_sync");
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk4);
         check($sformatf("pat%0d_phase", i), 32'(bus.phase), 32'(pt[i].ph));
         check($sformatf("pat%0d_nAE", i),   32'(bus.nAE),   32'(pt[i].nae));
         check($sformatf("pat%0d_nBE", i),   32'(bus.nBE),   32'(pt[i].nbe));
      end

      // misaligned CLK edge detected in phase 1 while locked
      wait_phase(2'd2, "inj_sync");
      gen_en  = 1'b0;
      clk_man = 1'b0;
      @(negedge clk4);
      check("inj_at_p3", 32'(bus.phase), 3);
      clk_man = 1'b1;
      @(negedge clk4);
      check("inj_p0_lock", 32'(bus.lock), 1);
      @(negedge clk4);
      check("inj_p1_phase", 32'(bus.phase), 1);
      check("inj_p1_err",   32'(bus.sync_err), 0);
      @(negedge clk4);
      check("inj_forced_phase", 32'(bus.phase), 0);
      check("inj_lock_drop",    32'(bus.lock), 0);
      check("inj_sync_err",     32'(bus.sync_err), 1);
      @(negedge clk4);
      check("inj_freerun_phase", 32'(bus.phase), 1);
      gen_en = 1'b1;
      wait_lock(120, "relock");
      check("sync_err_sticky", 32'(bus.sync_err), 1);

      // table of single transfers, one per Gigatron cycle
      for (int i = 0; i < 6; i++) begin
         wait_phase(2'd3, "vec_sync");
         bus.snoop     = vt[i].snp;
         bus.aux_we    = vt[i].we;
         bus.aux_addr  = vt[i].addr;
         bus.aux_wdata = vt[i].wdata;
         bus.sram_rd   = vt[i].rd;
         bus.aux_req   = 1'b1;
         for (int p = 0; p < 4; p++) begin
            @(negedge clk4);
            check($sformatf("v%0d_p%0d_phase", i, p), 32'(bus.phase),   p);
            check($sformatf("v%0d_p%0d_sel", i, p),   32'(bus.aux_sel), 32'(vt[i].sel[p]));
            check($sformatf("v%0d_p%0d_oe", i, p),    32'(bus.aux_oe),  32'(vt[i].oe[p]));
            check($sformatf("v%0d_p%0d_nwe", i, p),   32'(bus.aux_nwe), 32'(vt[i].nwe[p]));
            check($sformatf("v%0d_p%0d_ack", i, p),   32'(bus.aux_ack), 32'(vt[i].ack[p]));
            if (p >= 2) check($sformatf("v%0d_p%0d_rdata", i, p), 32'(bus.aux_rdata), 32'(vt[i].rdata));
            if (p == 2) bus.aux_req = 1'b0;
         end
      end
      bus.snoop = 1'b0;

      // starvation: snoop holds the slot for 201 Gigatron cycles
      wait_phase(2'd0, "starve_sync");
      bus.snoop   = 1'b1;
      bus.aux_we  = 1'b0;
      bus.sram_rd = 8'h5A;
      bus.aux_req = 1'b1;
      wraps = 0;
      n = 0;
      sel_seen = 1'b0;
      while (wraps < 201 && n < 2000) begin
         @(negedge clk4);
         n++;
         if (bus.aux_sel === 1'b1) sel_seen = 1'b1;
         if (bus.phase === 2'd0) begin
            wraps++;
            if (wraps == 200) check("starve_at_200", 32'(bus.aux_starved), 0);
         end
      end
      check("starve_wraps", wraps, 201);
      check("starve_at_201", 32'(bus.aux_starved), 1);
      check("starve_no_grant", 32'(sel_seen), 0);
      bus.snoop = 1'b0;
      repeat (4) @(negedge clk4);
      check("starve_grant_phase", 32'(bus.phase), 0);
      check("starve_grant_sel",   32'(bus.aux_sel), 1);
      check("starve_grant_ack0",  32'(bus.aux_ack), 0);
      @(negedge clk4);
      check("starve_ack_p1", 32'(bus.aux_ack), 0);
      @(negedge clk4);
      check("starve_ack_p2",   32'(bus.aux_ack), 1);
      check("starve_rdata",    32'(bus.aux_rdata), 32'h5A);
      bus.aux_req = 1'b0;
      @(negedge clk4);
      check("starve_ack_p3",   32'(bus.aux_ack), 0);
      check("starved_sticky",  32'(bus.aux_starved), 1);

      // CLK stops right after a grant: lock falls in ADDR and the transfer aborts
      wait_phase(2'd0, "abort_sync");
      gen_en        = 1'b0;
      clk_man       = 1'b0;
      bus.aux_we    = 1'b1;
      bus.aux_addr  = 19'h0ABCD;
      bus.aux_wdata = 8'h5C;
      bus.aux_req   = 1'b1;
      repeat (4) @(negedge clk4);
      check("abort_addr_phase", 32'(bus.phase), 0);
      check("abort_addr_sel",   32'(bus.aux_sel), 1);
      check("abort_lock_drop",  32'(bus.lock), 0);
      @(negedge clk4);
      check("abort_sel", 32'(bus.aux_sel), 0);
      check("abort_oe",  32'(bus.aux_oe), 0);
      check("abort_nwe", 32'(bus.aux_nwe), 1);
      acks = 0;
      repeat (20) begin
         if (bus.aux_ack === 1'b1) acks++;
         @(negedge clk4);
      end
      check("abort_no_ack", acks, 0);
      gen_en = 1'b1;
      acks = 0;
      repeat (150) begin
         @(negedge clk4);
         if (bus.aux_ack === 1'b1) begin
            acks++;
            bus.aux_req = 1'b0;
         end
      end
      check("retry_ack_once", acks, 1);
      check("retry_lock", 32'(bus.lock), 1);

      // asynchronous reset in the middle of a transfer
      wait_phase(2'd3, "arst_sync");
      bus.aux_we  = 1'b1;
      bus.aux_req = 1'b1;
      @(negedge clk4);
      check("arst_pre_sel", 32'(bus.aux_sel), 1);
      #2 nrst = 1'b0;
      #1;
      check("arst_phase",    32'(bus.phase), 0);
      check("arst_nAE",      32'(bus.nAE), 1);
      check("arst_nBE",      32'(bus.nBE), 1);
      check("arst_lock",     32'(bus.lock), 0);
      check("arst_sel",      32'(bus.aux_sel), 0);
      check("arst_oe",       32'(bus.aux_oe), 0);
      check("arst_nwe",      32'(bus.aux_nwe), 1);
      check("arst_ack",      32'(bus.aux_ack), 0);
      check("arst_rdata",    32'(bus.aux_rdata), 0);
      check("arst_starved",  32'(bus.aux_starved), 0);
      check("arst_sync_err", 32'(bus.sync_err), 0);
      bus.aux_req = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
